// File: rtl/if_id_skid_reg.sv
// IF/ID pipeline stage register with a 2-entry skid buffer.
//
// Sits between fetch and decode. The main entry drives the outputs; the skid
// entry catches the instruction accepted in the cycle decode stalls, so fetch
// can stream one instruction per cycle and in_ready never depends
// combinationally on out_ready or flush_in.
//
// Ports:
//   clk        clock, all state updates on the rising edge
//   rst        asynchronous active-low reset, clears both valid bits
//   flush_in   jump/branch redirect, discards every held entry
//   in_valid   fetch presents inst_in/pc_in
//   in_ready   stage can accept (registered, NOT skid valid)
//   inst_in    fetched instruction
//   pc_in      PC of inst_in
//   out_valid  inst_out/pc_out hold a real instruction
//   out_ready  decoder accepts this cycle
//   inst_out   instruction to decode, NOP_INST when out_valid=0
//   pc_out     PC to decode, BUBBLE_PC when out_valid=0
//   count      number of entries held, 0..2
module if_id_skid_reg #(
    parameter int unsigned          INST_W    = 32,
    parameter int unsigned          PC_W      = 32,
    parameter logic [INST_W-1:0]    NOP_INST  = 32'h0000_0013,
    parameter logic [PC_W-1:0]      BUBBLE_PC = '0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              flush_in,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [INST_W-1:0] inst_in,
    input  logic [PC_W-1:0]   pc_in,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [INST_W-1:0] inst_out,
    output logic [PC_W-1:0]   pc_out,
    output logic [1:0]        count
);

    logic              main_valid_q, main_valid_d;
    logic              skid_valid_q, skid_valid_d;
    logic [INST_W-1:0] main_inst_q;
    logic [PC_W-1:0]   main_pc_q;
    logic [INST_W-1:0] skid_inst_q;
    logic [PC_W-1:0]   skid_pc_q;

    logic in_fire;
    logic out_fire;
    logic main_load;       // main <= input
    logic main_from_skid;  // main <= skid
    logic skid_load;       // skid <= input

    assign in_ready = ~skid_valid_q;
    assign in_fire  = in_valid & in_ready;
    assign out_fire = main_valid_q & out_ready;

    always_comb begin
        main_valid_d   = main_valid_q;
        skid_valid_d   = skid_valid_q;
        main_load      = 1'b0;
        main_from_skid = 1'b0;
        skid_load      = 1'b0;
        if (flush_in) begin
            // Redirect wins: held entries and any same-cycle input are dropped.
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end else if (!main_valid_q) begin
            // Skid is never occupied while main is empty.
            if (in_fire) begin
                main_valid_d = 1'b1;
                main_load    = 1'b1;
            end
        end else if (out_fire) begin
            if (skid_valid_q) begin
                // Older skid entry moves up; in_ready was low so no input fired.
                main_from_skid = 1'b1;
                skid_valid_d   = 1'b0;
            end else if (in_fire) begin
                main_load = 1'b1;
            end else begin
                main_valid_d = 1'b0;
            end
        end else if (in_fire) begin
            skid_load    = 1'b1;
            skid_valid_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
        end else begin
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
        end
    end

    // Payload registers carry no reset; the valid bits gate their visibility.
    always_ff @(posedge clk) begin
        if (main_from_skid) begin
            main_inst_q <= skid_inst_q;
            main_pc_q   <= skid_pc_q;
        end else if (main_load) begin
            main_inst_q <= inst_in;
            main_pc_q   <= pc_in;
        end
        if (skid_load) begin
            skid_inst_q <= inst_in;
            skid_pc_q   <= pc_in;
        end
    end

    assign out_valid = main_valid_q;
    assign inst_out  = main_valid_q ? main_inst_q : NOP_INST;
    assign pc_out    = main_valid_q ? main_pc_q : BUBBLE_PC;
    assign count     = {1'b0, main_valid_q} + {1'b0, skid_valid_q};

endmodule

// File: tb/tb_if_id_skid_reg.sv
module tb_if_id_skid_reg;

    localparam logic [31:0] NOP = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        flush_in = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [31:0] inst_in = '0;
    logic [31:0] pc_in = '0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic [31:0] inst_out;
    logic [31:0] pc_out;
    logic [1:0]  count;

    int total = 0;
    int bad = 0;

    // Scoreboard of {inst, pc} the decoder must see, oldest first.
    logic [63:0] exp_q[$];

    if_id_skid_reg dut (
        .clk       (clk),
        .rst       (rst),
        .flush_in  (flush_in),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .inst_in   (inst_in),
        .pc_in     (pc_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .inst_out  (inst_out),
        .pc_out    (pc_out),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [31:0] inst_of(input logic [31:0] pc);
        return 32'hA000_0000 | pc;
    endfunction

    // Present one instruction for one cycle; acc says whether it is known to be accepted.
    task automatic drive(input logic [31:0] pc, input bit acc);
        in_valid = 1'b1;
        pc_in    = pc;
        inst_in  = inst_of(pc);
        if (acc) exp_q.push_back({inst_of(pc), pc});
        tick();
    endtask

    task automatic check_bubble(input string name);
        check({name, ".out_valid"}, 64'(out_valid), 64'd0);
        check({name, ".inst_out"}, 64'(inst_out), 64'(NOP));
        check({name, ".pc_out"}, 64'(pc_out), 64'd0);
        check({name, ".count"}, 64'(count), 64'd0);
        check({name, ".in_ready"}, 64'(in_ready), 64'd1);
    endtask

    // Monitor: every output beat that decode takes must match the scoreboard head.
    always @(negedge clk) begin
        if (out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_beat", {inst_out, pc_out}, 64'hFFFF_FFFF_FFFF_FFFF);
            end else begin
                check("beat", {inst_out, pc_out}, exp_q.pop_front());
            end
        end
    end

    initial begin
        // Reset held with fetch presenting garbage.
        in_valid = 1'b1;
        inst_in  = 32'hDEAD_BEEF;
        pc_in    = 32'h0000_0100;
        repeat (3) tick();
        check_bubble("reset");
        rst = 1'b1;
        in_valid = 1'b1;
        pc_in    = 32'h4;
        inst_in  = 32'h0050_0093;
        exp_q.push_back({32'h0050_0093, 32'h4});
        tick();
        in_valid = 1'b0;
        check("first.out_valid", 64'(out_valid), 64'd1);
        check("first.pc_out", 64'(pc_out), 64'h4);
        tick();
        check("first.drain", 64'(count), 64'd0);

        // Streaming, no gaps.
        for (int i = 0; i < 8; i++) begin
            drive(32'(i * 4), 1'b1);
            check("stream.out_valid", 64'(out_valid), 64'd1);
            check("stream.pc_out", 64'(pc_out), 64'(i * 4));
            check("stream.in_ready", 64'(in_ready), 64'd1);
        end
        in_valid = 1'b0;
        tick();
        check("stream.drain", 64'(count), 64'd0);

        // Single stall with 0x8 on the output and 0xC arriving.
        drive(32'h0, 1'b1);
        drive(32'h4, 1'b1);
        drive(32'h8, 1'b1);
        out_ready = 1'b0;
        drive(32'hC, 1'b1);
        check("stall.count", 64'(count), 64'd2);
        check("stall.in_ready", 64'(in_ready), 64'd0);
        check("stall.pc_out", 64'(pc_out), 64'h8);
        out_ready = 1'b1;
        drive(32'h10, 1'b0);  // refused, skid still full
        check("stall.count1", 64'(count), 64'd1);
        check("stall.in_ready1", 64'(in_ready), 64'd1);
        check("stall.pc_out1", 64'(pc_out), 64'hC);
        drive(32'h10, 1'b1);
        in_valid = 1'b0;
        check("stall.pc_out2", 64'(pc_out), 64'h10);
        tick();
        check("stall.drain", 64'(count), 64'd0);

        // Long stall: only two of five offered inputs are taken.
        out_ready = 1'b0;
        drive(32'h20, 1'b1);
        check("long.count1", 64'(count), 64'd1);
        check("long.in_ready1", 64'(in_ready), 64'd1);
        drive(32'h24, 1'b1);
        for (int i = 0; i < 4; i++) begin
            check("long.count", 64'(count), 64'd2);
            check("long.in_ready", 64'(in_ready), 64'd0);
            check("long.hold", {inst_out, pc_out}, {inst_of(32'h20), 32'h20});
            if (i < 3) drive(32'h28, 1'b0);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        check("long.pc_out", 64'(pc_out), 64'h24);
        tick();
        check("long.drain", 64'(count), 64'd0);

        // Flush with a full buffer and a same-cycle input.
        out_ready = 1'b0;
        drive(32'h30, 1'b1);
        drive(32'h34, 1'b1);
        check("flush.full", 64'(count), 64'd2);
        flush_in = 1'b1;
        drive(32'h40, 1'b0);
        flush_in = 1'b0;
        exp_q.delete();
        check_bubble("flush");
        out_ready = 1'b1;
        drive(32'h80, 1'b1);
        in_valid = 1'b0;
        check("flush.after", {inst_out, pc_out}, {inst_of(32'h80), 32'h80});
        tick();

        // Asynchronous reset between edges with two entries held.
        out_ready = 1'b0;
        drive(32'h50, 1'b1);
        drive(32'h54, 1'b1);
        in_valid = 1'b0;
        check("areset.full", 64'(count), 64'd2);
        #2;
        rst = 1'b0;
        #1;
        check_bubble("areset");
        exp_q.delete();
        #2;
        rst = 1'b1;
        out_ready = 1'b1;
        tick();
        check("areset.stale", 64'(out_valid), 64'd0);
        drive(32'h60, 1'b1);
        in_valid = 1'b0;
        check("areset.resume", 64'(pc_out), 64'h60);
        tick();
        tick();
        check("scoreboard.empty", 64'(exp_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
